// File: rtl/spi_tx_frame_buffer.sv
// spi_tx_frame_buffer
//
// Staging buffer between the CPU and the SPI shift engine. CPU bytes are
// queued in a synchronous FIFO; a small FSM pops them and assembles 8-bit
// frames (zero-extended) or 16-bit frames (first byte written is the MSB),
// presenting each frame through a valid/ready handshake.
//
// Optional feature: define SPI_TXBUF_OVF_EN to build the sticky overflow flag
// (set on write-while-full, cleared by ovf_clr). Without it, overflow is
// tied to 0 and ovf_clr is ignored.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   wr_en/wr_data CPU byte write (dropped when full)
//   full/empty    registered FIFO status
//   level         registered FIFO occupancy, 0..DEPTH
//   len16         frame length select, sampled in IDLE (1 = 16-bit)
//   frame_valid   frame_data holds a complete frame
//   frame_ready   SPI engine accepts the frame
//   frame_data    assembled frame
//   overflow      sticky write-while-full flag
//   ovf_clr       clears overflow

module spi_tx_frame_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic          len16,
    output logic          frame_valid,
    input  logic          frame_ready,
    output logic [15:0]   frame_data,
    output logic          overflow,
    input  logic          ovf_clr
);

    typedef enum logic [1:0] {StIdle, StFetchLo, StPresent} state_e;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          full_q;
    logic          empty_q;

    // Frame FSM state
    state_e        state_q;
    logic          len_q;
    logic          frame_valid_q;
    logic [15:0]   frame_data_q;

    logic          wr_acc;
    logic          pop;
    logic [7:0]    pop_data;

    // full is the registered flag, so a write at full is rejected even if
    // the FSM pops on the same edge.
    assign wr_acc   = wr_en & ~full_q;
    assign pop_data = mem[rd_ptr_q];

    // Pop decision mirrors the FSM transitions below; a 16-bit frame waits
    // until both bytes are queued so FETCH_LO can never see an empty FIFO.
    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            StIdle:    pop = len16 ? (level_q > (AW+1)'(1)) : ~empty_q;
            StFetchLo: pop = len_q;
            StPresent: pop = 1'b0;
            default:   pop = 1'b0;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (wr_acc && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!wr_acc && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Storage is not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            full_q  <= (level_d == (AW+1)'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            len_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!len16 && !empty_q) begin
                        frame_data_q  <= {8'h00, pop_data};
                        len_q         <= 1'b0;
                        frame_valid_q <= 1'b1;
                        state_q       <= StPresent;
                    end else if (len16 && (level_q > (AW+1)'(1))) begin
                        frame_data_q[15:8] <= pop_data;
                        len_q              <= 1'b1;
                        state_q            <= StFetchLo;
                    end
                end
                StFetchLo: begin
                    if (len_q) begin
                        frame_data_q[7:0] <= pop_data;
                    end
                    frame_valid_q <= 1'b1;
                    state_q       <= StPresent;
                end
                StPresent: begin
                    if (frame_ready) begin
                        frame_valid_q <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: begin
                    frame_valid_q <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

`ifdef SPI_TXBUF_OVF_EN
    logic ovf_q;

    // A new overflow event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full_q) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

    assign full        = full_q;
    assign empty       = empty_q;
    assign level       = level_q;
    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;

endmodule

// File: tb/tb_spi_tx_frame_buffer.sv
// Testbench for spi_tx_frame_buffer. Expected frames go into a scoreboard
// queue when bytes are written; a monitor pops and compares on every
// accepted handshake. Per-scenario tasks check status outputs inline.

module tb_spi_tx_frame_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
`ifdef SPI_TXBUF_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          len16;
    logic          frame_valid;
    logic          frame_ready;
    logic [15:0]   frame_data;
    logic          overflow;
    logic          ovf_clr;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb[$];

    spi_tx_frame_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .len16       (len16),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted frame must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got frame %h, expected no frame", frame_data);
            end else begin
                logic [15:0] exp;
                exp = sb.pop_front();
                if (frame_data !== exp) begin
                    bad++;
                    $display("FAIL sb_frame: got %h, expected %h", frame_data, exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end just after a rising edge.
    task automatic write_byte(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({full, empty, level, frame_valid, frame_data, overflow} !==
                {1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0}) begin
                bad++;
                $display("FAIL reset_idle cyc %0d: got full=%b empty=%b level=%0d valid=%b data=%h ovf=%b, expected 0 1 0 0 0000 0",
                         c, full, empty, level, frame_valid, frame_data, overflow);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_8bit;
        len16 = 1'b0;
        frame_ready = 1'b0;
        sb.push_back(16'h00A5);
        write_byte(8'hA5);
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b0 || level !== 4'd1) begin
            bad++;
            $display("FAIL b8_after_write: got valid=%b level=%0d, expected 0 1", frame_valid, level);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b1 || frame_data !== 16'h00A5 || empty !== 1'b1) begin
            bad++;
            $display("FAIL b8_present: got valid=%b data=%h empty=%b, expected 1 00a5 1",
                     frame_valid, frame_data, empty);
        end
        @(posedge clk);
        #1 frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b0 || empty !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("FAIL b8_accepted: got valid=%b empty=%b pending=%0d, expected 0 1 0",
                     frame_valid, empty, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_16bit_split;
        int cyc;
        len16 = 1'b1;
        frame_ready = 1'b0;
        write_byte(8'h12);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (frame_valid !== 1'b0 || level !== 4'd1) begin
                bad++;
                $display("FAIL b16_hold cyc %0d: got valid=%b level=%0d, expected 0 1",
                         c, frame_valid, level);
            end
            @(posedge clk);
            #1;
        end
        sb.push_back(16'h1234);
        write_byte(8'h34);
        cyc = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                cyc = c;
                break;
            end
        end
        total++;
        if (cyc != 2 || frame_data !== 16'h1234) begin
            bad++;
            $display("FAIL b16_latency: got %0d edges after 2nd write data=%h, expected 2 1234",
                     cyc, frame_data);
        end
        frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL b16_accept: got %0d pending frames, expected 0", sb.size());
        end
        len16 = 1'b0;
    endtask

    task automatic test_fill_overflow;
        len16 = 1'b0;
        frame_ready = 1'b0;
        for (int b = 1; b <= 9; b++) begin
            sb.push_back(16'(b));
            wr_data = 8'(b);
            wr_en   = 1'b1;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        total++;
        if (level !== 4'd8 || full !== 1'b1 || frame_valid !== 1'b1 || frame_data !== 16'h0001) begin
            bad++;
            $display("FAIL fill_full: got level=%0d full=%b valid=%b data=%h, expected 8 1 1 0001",
                     level, full, frame_valid, frame_data);
        end
        @(posedge clk);
        #1;
        write_byte(8'h0A);
        @(negedge clk);
        total++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== OvfEn) begin
            bad++;
            $display("FAIL fill_dropped: got level=%0d full=%b ovf=%b, expected 8 1 %b",
                     level, full, overflow, OvfEn);
        end
        @(posedge clk);
        #1 frame_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1;
        repeat (4) @(posedge clk);
        #1 frame_ready = 1'b0;
        @(negedge clk);
        total++;
        if (sb.size() != 0 || empty !== 1'b1 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL fill_drain: got pending=%0d empty=%b valid=%b, expected 0 1 0",
                     sb.size(), empty, frame_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame;
        len16 = 1'b1;
        frame_ready = 1'b0;
        write_byte(8'hDE);
        write_byte(8'hAD);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({full, empty, level, frame_valid, frame_data, overflow} !==
            {1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid: got full=%b empty=%b level=%0d valid=%b data=%h ovf=%b, expected 0 1 0 0 0000 0",
                     full, empty, level, frame_valid, frame_data, overflow);
        end
        @(posedge clk);
        #1;
        sb.push_back(16'hBEEF);
        write_byte(8'hBE);
        write_byte(8'hEF);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (frame_valid !== 1'b1 || frame_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL rst_after: got valid=%b data=%h, expected 1 beef", frame_valid, frame_data);
        end
        frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        len16 = 1'b0;
    endtask

    task automatic test_simul_wr_pop;
        len16 = 1'b0;
        frame_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            sb.push_back(16'h0070 + 16'(b));
            write_byte(8'h70 + 8'(b));
        end
        frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        @(negedge clk);
        total++;
        if (level !== 4'd3 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul_pre: got level=%0d valid=%b, expected 3 0", level, frame_valid);
        end
        // FSM is in IDLE with data queued: it pops on the same edge as this write.
        sb.push_back(16'h0074);
        write_byte(8'h74);
        @(negedge clk);
        total++;
        if (level !== 4'd3 || frame_valid !== 1'b1 || frame_data !== 16'h0071) begin
            bad++;
            $display("FAIL simul_level: got level=%0d valid=%b data=%h, expected 3 1 0071",
                     level, frame_valid, frame_data);
        end
        @(posedge clk);
        #1 frame_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1 frame_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL simul_drain: got %0d pending frames, expected 0", sb.size());
        end
    endtask

    task automatic test_ovf_clear;
        len16 = 1'b0;
        frame_ready = 1'b0;
        for (int b = 0; b < 10; b++) begin
            if (b < 9) sb.push_back(16'h0040 + 16'(b));
            wr_data = 8'h40 + 8'(b);
            wr_en   = 1'b1;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        total++;
        if (overflow !== OvfEn || level !== 4'd8) begin
            bad++;
            $display("FAIL ovf_set: got ovf=%b level=%0d, expected %b 8", overflow, level, OvfEn);
        end
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        @(negedge clk);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got ovf=%b, expected 0", overflow);
        end
        @(posedge clk);
        #1 ovf_clr = 1'b1;
        wr_data = 8'hFF;
        wr_en = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        total++;
        if (overflow !== OvfEn || level !== 4'd8) begin
            bad++;
            $display("FAIL ovf_set_wins: got ovf=%b level=%0d, expected %b 8", overflow, level, OvfEn);
        end
        @(posedge clk);
        #1 frame_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        #1;
        repeat (4) @(posedge clk);
        #1 frame_ready = 1'b0;
        total++;
        if (sb.size() != 0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drain: got pending=%0d empty=%b, expected 0 1", sb.size(), empty);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        len16 = 1'b0;
        frame_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_8bit();
        test_16bit_split();
        test_fill_overflow();
        test_reset_mid_frame();
        test_simul_wr_pop();
        test_ovf_clear();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
